// File: rtl/ser_arb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ser_arb_ctrl_pkg
// Shared definitions for the two-requester serialiser:
//   - DEFAULT_WIDTH : default serial word length
//   - state_e       : controller FSM state encoding
//   - rr_pick       : round-robin winner selection (one-hot result)
// -----------------------------------------------------------------------------
package ser_arb_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One-hot winner for a request vector. last_one is high when requester 1
  // received the previous grant, so a tie goes to requester 0 in that case.
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       last_one);
    logic [1:0] win;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_one ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// -----------------------------------------------------------------------------
// ser_shift_reg
// WIDTH-bit parallel-load, left-shifting register with zero fill; the MSB is
// the serial output.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : load data_i (takes priority over shift_i)
//   data_i    : parallel word
//   shift_i   : shift left one place, 0 into the LSB
//   msb_o     : current MSB
// -----------------------------------------------------------------------------
module ser_shift_reg
  import ser_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sreg_q;

  // NOTE: the data register is reset too, so the serial output is a known 0
  // straight out of reset rather than whatever the flops powered up with.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/ser_arb_ctrl.sv
// -----------------------------------------------------------------------------
// ser_arb_ctrl
// Round-robin arbiter between two requesters sharing one serialiser. The
// winner's word is captured at grant and shifted out MSB first, one bit per
// cycle with en high; a one-cycle DONE state follows the last bit.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req[1:0]      : level requests, held until ack
//   data0, data1  : parallel words of requester 0 / 1, sampled at grant
//   en            : shift enable; low freezes an in-progress word
//   ack[1:0]      : one-cycle pulse to the requester whose word was loaded
//   grant[1:0]    : one-hot shifter owner, 00 when idle
//   sout          : serial data, MSB first
//   sout_valid    : sout carries a word bit this cycle
//   done          : one-cycle pulse after the last bit
//   busy          : controller is not idle
// -----------------------------------------------------------------------------
module ser_arb_ctrl
  import ser_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             en,
  output logic [1:0]       ack,
  output logic [1:0]       grant,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       grant_q;
  logic [1:0]       ack_q;
  logic             last_one_q;   // 1: requester 1 held the previous grant

  logic [1:0]       winner;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] word_d;
  logic             sreg_msb;

  assign winner = rr_pick(req, last_one_q);
  assign load   = (state_q == ST_IDLE) && (req != 2'b00);
  assign shift  = (state_q == ST_SHIFT) && en;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    word_d = data0;
    if (winner[1]) word_d = data1;
  end

  ser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (word_d),
    .shift_i (shift),
    .msb_o   (sreg_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      ack_q      <= 2'b00;
      last_one_q <= 1'b1;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            grant_q    <= winner;
            ack_q      <= winner;
            last_one_q <= winner[1];
            cnt_q      <= '0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Grant stays visible through DONE and drops on the way to IDLE.
          grant_q <= 2'b00;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign sout       = (state_q == ST_SHIFT) && sreg_msb;
  assign sout_valid = (state_q == ST_SHIFT) && en;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/ser_arb_ctrl.md
SER_ARB_CTRL -- requirements
Module: ser_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, serial word length in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port req[1:0], input, 2, per-requester request; level, held until ack.
REQ-005 SHALL have ports data0 and data1, input, WIDTH each, parallel word of requester 0 and requester 1, sampled at grant.
REQ-006 SHALL have port en, input, 1, shift enable; 0 freezes an in-progress shift.
REQ-007 SHALL have port ack[1:0], output, 2, one-cycle pulse to the granted requester when its word is loaded.
REQ-008 SHALL have port grant[1:0], output, 2, one-hot owner of the shifter; 00 when idle.
REQ-009 SHALL have port sout, output, 1, serial data out, MSB first (left shift).
REQ-010 SHALL have port sout_valid, output, 1, high when sout carries a word bit.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last bit.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-014 IDLE, at least one req bit high at the edge -> load the winner's data into the WIDTH-bit shift register, set grant, pulse ack for the following cycle, clear the bit counter, go to SHIFT.
REQ-015 Arbitration SHALL be round-robin: a single requester wins; if both request, the one not granted last wins; the last-grant pointer SHALL update on every grant.
REQ-016 SHIFT: sout = sreg[WIDTH-1], sout_valid = en; on each edge with en=1, sreg shifts left with 0 filled into the LSB and the counter increments.
REQ-017 SHIFT with en=0 SHALL hold sreg, counter and sout; sout_valid = 0.
REQ-018 SHIFT, edge with en=1 and counter = WIDTH-1 -> go to DONE; exactly WIDTH valid bits per word.
REQ-019 DONE lasts exactly one cycle: done=1, grant held, sout_valid=0, then IDLE; a new grant is possible on the IDLE cycle after DONE (minimum 1 idle cycle between words).
REQ-020 req changes while busy SHALL be ignored until IDLE; the captured word SHALL NOT be affected by data0/data1 changes after the grant.
REQ-021 Requester deasserting req after ack SHALL NOT abort the transfer.

Reset
REQ-022 rst high SHALL immediately force IDLE, sreg=0, counter=0, grant=00, ack=00, sout=0, sout_valid=0, done=0, busy=0, and the last-grant pointer to requester 1, so that requester 0 wins the first tie.
REQ-023 rst mid-transfer SHALL discard the word with no done pulse; arbitration resumes on the first edge after release.

Structure
REQ-024 A shared package SHALL hold the FSM state enum and the default WIDTH constant.
REQ-025 The shifter SHALL be a sub-module ser_shift_reg (parallel load, shift enable, serial out); FSM, arbiter and counter SHALL live in ser_arb_ctrl.

Verification
REQ-026 Reset, then req=01, data0=8'hA5, en=1 -> ack=01 one cycle, sout sequence 1,0,1,0,0,1,0,1 over 8 valid cycles, done pulse, busy low.
REQ-027 req=11 from reset -> requester 0 served first, then requester 1; if both are still requesting, requester 0 again (alternation).
REQ-028 en low for 3 cycles after bit 2 of 8'hF0 -> sout holds 1 with sout_valid=0 for those cycles; total valid bits still 8, order intact.
REQ-029 rst pulsed after bit 4 -> all outputs 0 immediately, no done; with req held, a fresh grant and full word follow.
REQ-030 data0 changed during SHIFT and req dropped after ack -> serial output equals the word captured at grant.
REQ-031 WIDTH=2, back-to-back req=01 -> pattern SHIFT(2), DONE, IDLE, grant, with a 1-cycle idle gap.
